snes_mem_req: RTL and testbench
===============================

Name: snes_mem_req

Overview:
- Downstream consumer of the SNES address decoder. Turns each asynchronous SNES read or write strobe into exactly one request on the memory-arbiter port.
- Latches the decoded ROM_ADDR, ROM_HIT and IS_WRITABLE at a settle point. Runs a req/ack handshake with the SRAM0 arbiter.
- Returns read data to the SNES data-bus driver and counts dropped writes.

Parameters:
SYNC_STAGES, 2, flops in each strobe synchroniser (min 2)
RD_SETTLE, 3, CLK cycles after detected /RD fall before address/hit latch
WR_SETTLE, 4, CLK cycles after detected /WR fall before address/data latch

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
SNES_READ  in  1  SNES /RD, active low, asynchronous
SNES_WRITE  in  1  SNES /WR, active low, asynchronous
SNES_DATA_IN  in  8  SNES data bus (write data)
ROM_ADDR  in  24  decoded memory address
ROM_HIT  in  1  decoded address maps to SRAM0
IS_WRITABLE  in  1  decoded address is writable
MEM_REQ  out  1  request to arbiter
MEM_WE  out  1  1=write, 0=read; valid while MEM_REQ
MEM_ADDR  out  24  request address; valid while MEM_REQ
MEM_WDATA  out  8  write data; valid while MEM_REQ & MEM_WE
MEM_ACK  in  1  arbiter accept/complete, one-cycle pulse
MEM_RDATA  in  8  read data, valid in MEM_ACK cycle
SNES_RDATA  out  8  last read data for SNES bus driver
SNES_RDATA_VALID  out  1  read data valid for current /RD
BUSY  out  1  FSM not in IDLE
WR_DROP_CNT  out  8  saturating count of writes to non-writable hits

Behaviour:
Reset values (async on RST high):
- All outputs 0.
- FSM in IDLE; synchronisers preset to 1 (strobes inactive); pending flag 0.

Strobe detection:
- Each strobe passes through SYNC_STAGES flops plus one edge-detect flop.
- The fall pulse is one cycle wide, SYNC_STAGES+1 cycles after the first CLK edge that samples it low.
- The rise pulse is detected the same way.

FSM states:
- IDLE: on rd_fall go to RD_SETTLE (counter loaded). Else on wr_fall go to WR_SETTLE. If both fall in the same cycle, the read wins and the write is dropped (no count).
- RD_SETTLE: count RD_SETTLE cycles.
  - rd_rise before expiry → IDLE, no request.
  - On expiry, latch ROM_ADDR/ROM_HIT. Hit → RD_REQ. Miss → IDLE.
- RD_REQ: MEM_REQ=1, MEM_WE=0, MEM_ADDR=latched.
  - Hold until MEM_ACK is sampled.
  - In the ack cycle, capture MEM_RDATA into SNES_RDATA. SNES_RDATA_VALID=1 from the next cycle. MEM_REQ=0 from the next cycle. Go to IDLE.
- WR_SETTLE: count WR_SETTLE cycles.
  - wr_rise before expiry → IDLE, no request.
  - On expiry, latch ROM_ADDR, SNES_DATA_IN, ROM_HIT, IS_WRITABLE.
  - Hit & writable → WR_REQ.
  - Hit & !writable → increment WR_DROP_CNT (saturate at 255), then IDLE.
  - Miss → IDLE.
- WR_REQ: MEM_REQ=1, MEM_WE=1 until MEM_ACK, then IDLE.

Request and data rules:
- With defaults, MEM_REQ rises 7 cycles after the first CLK edge sampling /RD low (3 sync + 1 settle-entry + 3 settle).
- Once MEM_REQ is high, MEM_ADDR/MEM_WE/MEM_WDATA are stable until MEM_ACK.
- MEM_REQ never drops without MEM_ACK. A strobe rise during RD_REQ/WR_REQ does not abort the request.
- MEM_ACK while MEM_REQ=0 is ignored.
- SNES_RDATA_VALID clears on the next rd_fall. SNES_RDATA holds its value.

Pending request:
- A fall pulse arriving outside IDLE sets a one-deep pending flag with its type.
- On return to IDLE the pending type is taken immediately, entering its SETTLE state with the full count.
- A second fall while pending overwrites the pending type.

Reset mid-operation: everything returns to reset values immediately and any in-flight request is abandoned. The arbiter tolerates a withdrawn request under RST.

BUSY = (state != IDLE).

Test Plan:
- /RD low 20 cycles, ROM_ADDR=0x1234AB, ROM_HIT=1, MEM_ACK 2 cycles after MEM_REQ with MEM_RDATA=0x5A → one MEM_REQ (MEM_WE=0, MEM_ADDR=0x1234AB) rising 7 cycles after /RD sampled low; SNES_RDATA=0x5A, SNES_RDATA_VALID=1.
- /WR low, SNES_DATA_IN=0xC3, ROM_ADDR=0xE00010, ROM_HIT=1, IS_WRITABLE=1 → one write request with MEM_WDATA=0xC3, MEM_ADDR=0xE00010, MEM_WE=1.
- 300 writes with ROM_HIT=1, IS_WRITABLE=0 → no MEM_REQ; WR_DROP_CNT=255 (saturated).
- /RD pulse of 4 cycles (rise before settle expiry) → no MEM_REQ, BUSY returns to 0.
- Read with MEM_ACK withheld 10 cycles while a /WR fall arrives → MEM_REQ held with stable address; the write issues after the read ack; the two requests are separated by WR_SETTLE+1 cycles.
- RST pulsed while MEM_REQ=1 → MEM_REQ=0 immediately; all outputs 0; the next /RD operates normally.

Source files
------------

// File: rtl/snes_mem_req_if.sv
// Request/acknowledge port between the SNES request generator and the SRAM0 arbiter.
// The master raises mem_req and holds we/addr/wdata stable until the arbiter pulses mem_ack.
interface snes_mem_req_if;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/snes_mem_req.sv
// Converts asynchronous SNES /RD and /WR strobes into single arbiter requests,
// returns read data to the SNES bus driver and counts writes to read-only hits.
module snes_mem_req #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_SETTLE   = 3,
  parameter int WR_SETTLE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snes_read,
  input  logic                  snes_write,
  input  logic [7:0]            snes_data_in,
  input  logic [23:0]           rom_addr,
  input  logic                  rom_hit,
  input  logic                  is_writable,
  snes_mem_req_if.master        mem,
  output logic [7:0]            snes_rdata,
  output logic                  snes_rdata_valid,
  output logic                  busy,
  output logic [7:0]            wr_drop_cnt
);

  localparam int CHAIN_W    = SYNC_STAGES + 1;
  localparam int MAX_SETTLE = (RD_SETTLE > WR_SETTLE) ? RD_SETTLE : WR_SETTLE;
  localparam int CNT_W      = $clog2(MAX_SETTLE + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_SETTLE_S = 3'd1;
  localparam logic [2:0] RD_REQ    = 3'd2;
  localparam logic [2:0] WR_SETTLE_S = 3'd3;
  localparam logic [2:0] WR_REQ    = 3'd4;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_SETTLE);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_SETTLE);

  // The top bit of each chain is the edge-detect flop; the rest synchronise the strobe.
  logic [CHAIN_W-1:0] rd_chain;
  logic [CHAIN_W-1:0] wr_chain;
  logic               rd_fall;
  logic               rd_rise;
  logic               wr_fall;
  logic               wr_rise;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               pend;
  logic               pend_rd;

  logic               resume_pend;
  logic               resume_rd;
  logic [2:0]         resume_state;
  logic [CNT_W-1:0]   resume_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_chain <= '1;
      wr_chain <= '1;
      rd_fall  <= 1'b0;
      rd_rise  <= 1'b0;
      wr_fall  <= 1'b0;
      wr_rise  <= 1'b0;
    end else begin
      rd_chain <= {rd_chain[CHAIN_W-2:0], snes_read};
      wr_chain <= {wr_chain[CHAIN_W-2:0], snes_write};
      rd_fall  <= rd_chain[CHAIN_W-1] & ~rd_chain[CHAIN_W-2];
      rd_rise  <= ~rd_chain[CHAIN_W-1] & rd_chain[CHAIN_W-2];
      wr_fall  <= wr_chain[CHAIN_W-1] & ~wr_chain[CHAIN_W-2];
      wr_rise  <= ~wr_chain[CHAIN_W-1] & wr_chain[CHAIN_W-2];
    end
  end

  // Where to go when an operation finishes: a fall arriving this very cycle counts as the newest pending strobe.
  always_comb begin
    resume_pend  = pend | rd_fall | wr_fall;
    resume_rd    = rd_fall ? 1'b1 : (wr_fall ? 1'b0 : pend_rd);
    resume_state = IDLE;
    resume_cnt   = '0;
    if (resume_pend) begin
      resume_state = resume_rd ? RD_SETTLE_S : WR_SETTLE_S;
      resume_cnt   = resume_rd ? RD_LOAD : WR_LOAD;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      pend             <= 1'b0;
      pend_rd          <= 1'b0;
      mem.mem_req      <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wdata    <= '0;
      snes_rdata       <= '0;
      snes_rdata_valid <= 1'b0;
      wr_drop_cnt      <= '0;
    end else begin
      if (state != IDLE && (rd_fall || wr_fall)) begin
        pend    <= 1'b1;
        pend_rd <= rd_fall;
      end

      case (state)
        IDLE: begin
          pend <= 1'b0;
          if (rd_fall) begin
            state <= RD_SETTLE_S;
            cnt   <= RD_LOAD;
          end else if (wr_fall) begin
            state <= WR_SETTLE_S;
            cnt   <= WR_LOAD;
          end
        end

        RD_SETTLE_S: begin
          if (rd_rise) begin
            state <= resume_state;
            cnt   <= resume_cnt;
            pend  <= 1'b0;
          end else if (cnt == '0) begin
            mem.mem_addr <= rom_addr;
            if (rom_hit) begin
              state       <= RD_REQ;
              mem.mem_req <= 1'b1;
              mem.mem_we  <= 1'b0;
            end else begin
              state <= resume_state;
              cnt   <= resume_cnt;
              pend  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        RD_REQ: begin
          if (mem.mem_ack) begin
            snes_rdata       <= mem.mem_rdata;
            snes_rdata_valid <= 1'b1;
            mem.mem_req      <= 1'b0;
            state            <= resume_state;
            cnt              <= resume_cnt;
            pend             <= 1'b0;
          end
        end

        WR_SETTLE_S: begin
          if (wr_rise) begin
            state <= resume_state;
            cnt   <= resume_cnt;
            pend  <= 1'b0;
          end else if (cnt == '0) begin
            mem.mem_addr  <= rom_addr;
            mem.mem_wdata <= snes_data_in;
            if (rom_hit && is_writable) begin
              state       <= WR_REQ;
              mem.mem_req <= 1'b1;
              mem.mem_we  <= 1'b1;
            end else begin
              if (rom_hit && wr_drop_cnt != 8'hFF) begin
                wr_drop_cnt <= wr_drop_cnt + 8'd1;
              end
              state <= resume_state;
              cnt   <= resume_cnt;
              pend  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        WR_REQ: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            state       <= resume_state;
            cnt         <= resume_cnt;
            pend        <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // A new read strobe invalidates the data held for the previous one.
      if (rd_fall) begin
        snes_rdata_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snes_mem_req.sv
// Directed bench for snes_mem_req: the bench plays both the SNES bus and the SRAM0 arbiter.
module tb_snes_mem_req;
  logic        clk;
  logic        rst;
  logic        snes_read;
  logic        snes_write;
  logic [7:0]  snes_data_in;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_rdata;
  logic        snes_rdata_valid;
  logic        busy;
  logic [7:0]  wr_drop_cnt;

  int compared;
  int mismatched;
  int req_rises;
  logic req_prev;

  snes_mem_req_if bus ();

  snes_mem_req dut (
    .clk              (clk),
    .rst              (rst),
    .snes_read        (snes_read),
    .snes_write       (snes_write),
    .snes_data_in     (snes_data_in),
    .rom_addr         (rom_addr),
    .rom_hit          (rom_hit),
    .is_writable      (is_writable),
    .mem              (bus),
    .snes_rdata       (snes_rdata),
    .snes_rdata_valid (snes_rdata_valid),
    .busy             (busy),
    .wr_drop_cnt      (wr_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    req_rises = 0;
    req_prev  = 1'b0;
  end

  always @(posedge clk) begin
    if (bus.mem_req && !req_prev) req_rises++;
    req_prev = bus.mem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] data,
                               input logic [23:0] addr, input logic hit, input logic writable);
    snes_read    = rd;
    snes_write   = wr;
    snes_data_in = data;
    rom_addr     = addr;
    rom_hit      = hit;
    is_writable  = writable;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReq(input int limit, output int n);
    n = 0;
    while (!bus.mem_req && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic ackCycle(input logic [7:0] data);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    step();
    bus.mem_ack   = 1'b0;
  endtask

  int  n;
  int  rises_before;
  logic addr_moved;

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    applyStimulus(1'b1, 1'b1, 8'h00, 24'h000000, 1'b0, 1'b0);
    step();
    step();
    checkOutput("reset_req",   {31'd0, bus.mem_req}, 32'd0);
    checkOutput("reset_busy",  {31'd0, busy}, 32'd0);
    checkOutput("reset_addr",  {8'd0, bus.mem_addr}, 32'd0);
    checkOutput("reset_drop",  {24'd0, wr_drop_cnt}, 32'd0);
    checkOutput("reset_valid", {31'd0, snes_rdata_valid}, 32'd0);
    rst = 1'b0;
    repeat (4) step();

    $display("[TB] basic read");
    applyStimulus(1'b0, 1'b1, 8'h00, 24'h1234AB, 1'b1, 1'b0);
    waitReq(20, n);
    checkOutput("rd_latency", n, 32'd8);
    checkOutput("rd_we",   {31'd0, bus.mem_we}, 32'd0);
    checkOutput("rd_addr", {8'd0, bus.mem_addr}, 32'h1234AB);
    step();
    checkOutput("rd_req_held", {31'd0, bus.mem_req}, 32'd1);
    ackCycle(8'h5A);
    checkOutput("rd_req_drop", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rd_data",  {24'd0, snes_rdata}, 32'h5A);
    checkOutput("rd_valid", {31'd0, snes_rdata_valid}, 32'd1);
    repeat (10) step();
    snes_read = 1'b1;
    repeat (6) step();
    checkOutput("rd_one_req", req_rises, 32'd1);

    $display("[TB] stray ack while idle");
    ackCycle(8'hEE);
    step();
    checkOutput("idle_ack_data",  {24'd0, snes_rdata}, 32'h5A);
    checkOutput("idle_ack_valid", {31'd0, snes_rdata_valid}, 32'd1);
    checkOutput("idle_ack_busy",  {31'd0, busy}, 32'd0);

    $display("[TB] basic write");
    applyStimulus(1'b1, 1'b0, 8'hC3, 24'hE00010, 1'b1, 1'b1);
    waitReq(20, n);
    checkOutput("wr_latency", n, 32'd9);
    checkOutput("wr_we",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("wr_addr",  {8'd0, bus.mem_addr}, 32'hE00010);
    checkOutput("wr_wdata", {24'd0, bus.mem_wdata}, 32'hC3);
    ackCycle(8'h00);
    checkOutput("wr_req_drop", {31'd0, bus.mem_req}, 32'd0);
    snes_write = 1'b1;
    repeat (6) step();

    $display("[TB] short read pulse");
    rises_before = req_rises;
    applyStimulus(1'b0, 1'b1, 8'h00, 24'h00BEEF, 1'b1, 1'b0);
    repeat (4) step();
    snes_read = 1'b1;
    step();
    checkOutput("short_busy_mid", {31'd0, busy}, 32'd1);
    checkOutput("short_valid_clr", {31'd0, snes_rdata_valid}, 32'd0);
    repeat (8) step();
    checkOutput("short_busy_end", {31'd0, busy}, 32'd0);
    checkOutput("short_no_req", req_rises, rises_before);
    checkOutput("short_data_hold", {24'd0, snes_rdata}, 32'h5A);

    $display("[TB] read held off with pending write");
    applyStimulus(1'b0, 1'b1, 8'h00, 24'h00ABCD, 1'b1, 1'b0);
    waitReq(20, n);
    checkOutput("pend_rd_latency", n, 32'd8);
    applyStimulus(1'b1, 1'b0, 8'h99, 24'hE00020, 1'b1, 1'b1);
    addr_moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.mem_addr !== 24'h00ABCD || bus.mem_we !== 1'b0 || bus.mem_req !== 1'b1) addr_moved = 1'b1;
    end
    checkOutput("pend_rd_stable", {31'd0, addr_moved}, 32'd0);
    ackCycle(8'h77);
    checkOutput("pend_rd_drop",  {31'd0, bus.mem_req}, 32'd0);
    checkOutput("pend_rd_data",  {24'd0, snes_rdata}, 32'h77);
    checkOutput("pend_rd_valid", {31'd0, snes_rdata_valid}, 32'd1);
    waitReq(20, n);
    checkOutput("pend_wr_gap",   n, 32'd5);
    checkOutput("pend_wr_we",    {31'd0, bus.mem_we}, 32'd1);
    checkOutput("pend_wr_addr",  {8'd0, bus.mem_addr}, 32'hE00020);
    checkOutput("pend_wr_wdata", {24'd0, bus.mem_wdata}, 32'h99);
    ackCycle(8'h00);
    snes_write = 1'b1;
    repeat (6) step();

    $display("[TB] writes to read-only hits");
    rises_before = req_rises;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h11, 24'hC00000, 1'b1, 1'b0);
      repeat (12) step();
      snes_write = 1'b1;
      repeat (6) step();
      if (i == 0) checkOutput("drop_first", {24'd0, wr_drop_cnt}, 32'd1);
      if (i == 254) checkOutput("drop_255th", {24'd0, wr_drop_cnt}, 32'd255);
    end
    checkOutput("drop_saturated", {24'd0, wr_drop_cnt}, 32'd255);
    checkOutput("drop_no_req", req_rises, rises_before);

    $display("[TB] reset during request");
    applyStimulus(1'b0, 1'b1, 8'h00, 24'h112233, 1'b1, 1'b0);
    waitReq(20, n);
    checkOutput("rst_pre_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b1;
    snes_read = 1'b1;
    #1;
    checkOutput("rst_req",   {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_addr",  {8'd0, bus.mem_addr}, 32'd0);
    checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
    checkOutput("rst_drop",  {24'd0, wr_drop_cnt}, 32'd0);
    checkOutput("rst_rdata", {24'd0, snes_rdata}, 32'd0);
    checkOutput("rst_valid", {31'd0, snes_rdata_valid}, 32'd0);
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
    applyStimulus(1'b0, 1'b1, 8'h00, 24'h445566, 1'b1, 1'b0);
    waitReq(20, n);
    checkOutput("post_rst_latency", n, 32'd8);
    checkOutput("post_rst_addr", {8'd0, bus.mem_addr}, 32'h445566);
    ackCycle(8'h3C);
    checkOutput("post_rst_data", {24'd0, snes_rdata}, 32'h3C);
    snes_read = 1'b1;
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
